// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transmit path (spi_master_serializer).
//   state_e        : serializer FSM states (IDLE / ARMED / SHIFT)
//   DEFAULT_WIDTH  : default frame width in bits
//   MOSI_IDLE      : level driven on MOSI when no frame is in flight
//   cnt_width()    : bit counter width able to hold 0..WIDTH
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing loaded
    ARMED = 2'd1,  // CPHA=1 frame loaded, waiting for first leading edge
    SHIFT = 2'd2   // bits being driven onto MOSI
  } state_e;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic MOSI_IDLE     = 1'b0;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_tx_hold.sv
// -----------------------------------------------------------------------------
// spi_tx_hold
// One-entry valid/ready holding buffer in front of the SPI shift register.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-low reset
//   i_clear          : synchronous flush (abort); blocks a same-cycle write
//   i_valid, i_data  : write side; accepted when i_valid && o_ready
//   o_ready          : buffer empty
//   i_pop            : consumer takes the entry this cycle
//   o_full, o_data   : read side
// -----------------------------------------------------------------------------
module spi_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (i_clear) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (i_pop) begin
      full_d = 1'b0;
    end else if (i_valid && !full_q) begin
      full_d = 1'b1;
      data_d = i_data;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_ready = !full_q;
  assign o_full  = full_q;
  assign o_data  = data_q;

endmodule

// File: rtl/spi_master_serializer.sv
// -----------------------------------------------------------------------------
// spi_master_serializer
// SPI master transmit path. Parallel frames arrive over valid/ready into a
// one-entry holding buffer and are shifted onto MOSI one bit per SCLK edge
// strobe. A full holding buffer at frame completion is loaded on the same
// edge, so consecutive frames run with no idle bit.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   i_data, i_valid     : frame to send; accepted when i_valid && o_ready
//   o_ready             : holding buffer empty
//   i_lead_en/i_trail_en: one-cycle strobes at SCLK leading/trailing edges
//   i_cpha              : 0 = drive on trail, 1 = drive on lead (latched at load)
//   i_abort             : synchronous flush of buffer and frame
//   o_mosi              : serial data out
//   o_busy              : a frame is in the shift register
//   o_done              : one-cycle pulse after the last bit was sampled
// Build option: define SPI_SER_MSB_FIRST_EN for MSB-first order
// (default LSB first).
// -----------------------------------------------------------------------------
module spi_master_serializer
  import spi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_lead_en,
  input  logic             i_trail_en,
  input  logic             i_cpha,
  input  logic             i_abort,
  output logic             o_mosi,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpha_q, cpha_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_pop;
  logic             load;

  spi_tx_hold #(.WIDTH(WIDTH)) u_hold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_abort),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_pop   (hold_pop),
    .o_full  (hold_full),
    .o_data  (hold_data)
  );

  // The shift register always presents the next bit to drive at one end;
  // first_bit picks it and advance discards it.
`ifdef SPI_SER_MSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return v << 1;
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return v >> 1;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    cpha_d   = cpha_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    load     = 1'b0;
    hold_pop = 1'b0;

    if (i_abort) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
      mosi_d  = MOSI_IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hold_full) load = 1'b1;
        end
        ARMED: begin
          // A lead coinciding with a trail is illegal; the lead is dropped.
          if (i_lead_en && !i_trail_en) begin
            mosi_d  = first_bit(shift_q);
            shift_d = advance(shift_q);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (i_trail_en) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              done_d = 1'b1;
              if (hold_full) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
                mosi_d  = MOSI_IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (!cpha_q) begin
                mosi_d  = first_bit(shift_q);
                shift_d = advance(shift_q);
              end
            end
          end else if (i_lead_en && cpha_q) begin
            mosi_d  = first_bit(shift_q);
            shift_d = advance(shift_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Load overrides the per-state updates: fresh frame, fresh phase.
    if (load) begin
      hold_pop = 1'b1;
      cnt_d    = '0;
      cpha_d   = i_cpha;
      if (!i_cpha) begin
        mosi_d  = first_bit(hold_data);
        shift_d = advance(hold_data);
        state_d = SHIFT;
      end else begin
        shift_d = hold_data;
        state_d = ARMED;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      cpha_q  <= 1'b0;
      mosi_q  <= MOSI_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      cpha_q  <= cpha_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign o_mosi = mosi_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_spi_master_serializer.sv
// -----------------------------------------------------------------------------
// tb_spi_master_serializer
// Directed bench for spi_master_serializer (default LSB-first build).
// Stimulus pushes expected MOSI bits and expected completed frames into
// queues; a monitor samples MOSI on every sampling strobe and compares, and
// on every o_done compares the byte assembled from the sampled bits.
// -----------------------------------------------------------------------------
module tb_spi_master_serializer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       i_lead_en;
  logic       i_trail_en;
  logic       i_cpha;
  logic       i_abort;
  logic       o_mosi;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_errors = 0;

  logic       exp_bits[$];
  logic [7:0] exp_done[$];
  logic       samp_cpha  = 1'b0;
  logic       watch_busy = 1'b0;
  int         busy_drops = 0;
  logic [7:0] rx         = '0;
  logic       ff_acc     = 1'b0;

  spi_master_serializer #(.WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_lead_en  (i_lead_en),
    .i_trail_en (i_trail_en),
    .i_cpha     (i_cpha),
    .i_abort    (i_abort),
    .o_mosi     (o_mosi),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One strobe cycle followed by one quiet cycle.
  task automatic strobe(input logic lead);
    if (lead) i_lead_en = 1'b1;
    else      i_trail_en = 1'b1;
    tick();
    i_lead_en  = 1'b0;
    i_trail_en = 1'b0;
    tick();
  endtask

  task automatic pairs(input int n);
    repeat (n) begin
      strobe(1'b1);
      strobe(1'b0);
    end
  endtask

  task automatic write(input logic [7:0] b);
    logic hs;
    hs      = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      hs = o_ready;
      tick();
    end
    i_valid = 1'b0;
    if (!hs) begin
      n_checks++;
      n_errors++;
      $display("FAIL write_timeout: data %0h never accepted", b);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) exp_bits.push_back(b[k]);
  endtask

  task automatic push_frame(input logic [7:0] b);
    push_bits(b, 8);
    exp_done.push_back(b);
  endtask

  // Monitor: compares MOSI at each sampling strobe and each o_done pulse.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst === 1'b1) begin
        if (watch_busy && !o_busy) busy_drops++;
        if (o_busy && ((!samp_cpha && i_lead_en) || (samp_cpha && i_trail_en))) begin
          rx = {o_mosi, rx[7:1]};
          if (exp_bits.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_bit: got %0b with no bit expected (t=%0t)", o_mosi, $time);
          end else begin
            check("mosi_bit", 16'(o_mosi), 16'(exp_bits.pop_front()));
          end
        end
        if (o_done) begin
          if (exp_done.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: pulse with no frame expected (t=%0t)", $time);
          end else begin
            check("done_frame", 16'(rx), 16'(exp_done.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    i_rst      = 1'b0;
    i_data     = '0;
    i_valid    = 1'b0;
    i_lead_en  = 1'b0;
    i_trail_en = 1'b0;
    i_cpha     = 1'b0;
    i_abort    = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_mosi",  16'(o_mosi),  16'd0);
    check("rst_ready", 16'(o_ready), 16'd1);
    check("rst_busy",  16'(o_busy),  16'd0);
    check("rst_done",  16'(o_done),  16'd0);
    i_rst = 1'b1;
    tick();

    // CPHA=0, 0xA5
    i_cpha = 1'b0; samp_cpha = 1'b0;
    push_frame(8'hA5);
    write(8'hA5);
    tick();
    check("a5_busy",  16'(o_busy),  16'd1);
    check("a5_bit0",  16'(o_mosi),  16'd1);
    check("a5_ready", 16'(o_ready), 16'd1);
    pairs(8);
    check("a5_end_mosi", 16'(o_mosi), 16'd0);
    check("a5_end_busy", 16'(o_busy), 16'd0);

    // CPHA=1, 0x3C
    i_cpha = 1'b1; samp_cpha = 1'b1;
    push_frame(8'h3C);
    write(8'h3C);
    tick();
    check("3c_busy",  16'(o_busy), 16'd1);
    check("3c_armed", 16'(o_mosi), 16'd0);
    pairs(8);
    check("3c_end_busy", 16'(o_busy), 16'd0);

    // Back-to-back 0x01 then 0x80
    i_cpha = 1'b0; samp_cpha = 1'b0;
    push_frame(8'h01);
    push_frame(8'h80);
    write(8'h01);
    tick();
    watch_busy = 1'b1;
    pairs(2);
    write(8'h80);
    check("b2b_ready_full", 16'(o_ready), 16'd0);
    pairs(13);
    watch_busy = 1'b0;
    pairs(1);
    check("b2b_busy_drops", 16'(busy_drops), 16'd0);
    check("b2b_end_busy", 16'(o_busy), 16'd0);

    // Held i_valid with 0xFF while the buffer is full
    push_frame(8'hC3);
    push_frame(8'h81);
    push_frame(8'hFF);
    write(8'hC3);
    tick();
    write(8'h81);
    check("hold_ready_low", 16'(o_ready), 16'd0);
    ff_acc = 1'b0;
    fork
      begin
        write(8'hFF);
        ff_acc = 1'b1;
      end
      begin
        pairs(7);
        check("ff_not_yet", 16'(ff_acc), 16'd0);
        check("ff_ready_low", 16'(o_ready), 16'd0);
        pairs(1);
      end
    join
    check("ff_accepted", 16'(ff_acc), 16'd1);
    pairs(16);
    check("ff_end_busy", 16'(o_busy), 16'd0);

    // Abort at bit 4 of 0x55, with a competing write in the abort cycle
    push_bits(8'h55, 4);
    write(8'h55);
    tick();
    pairs(4);
    i_abort = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    tick();
    i_abort = 1'b0; i_valid = 1'b0;
    check("abort_mosi",  16'(o_mosi),  16'd0);
    check("abort_busy",  16'(o_busy),  16'd0);
    check("abort_ready", 16'(o_ready), 16'd1);
    tick();
    check("abort_no_load", 16'(o_busy), 16'd0);
    push_frame(8'h0F);
    write(8'h0F);
    tick();
    pairs(8);
    check("0f_end_busy", 16'(o_busy), 16'd0);

    // Reset mid-frame with the buffer full
    push_bits(8'h96, 3);
    write(8'h96);
    tick();
    write(8'h69);
    pairs(3);
    i_rst = 1'b0;
    #2;
    check("mrst_mosi",  16'(o_mosi),  16'd0);
    check("mrst_ready", 16'(o_ready), 16'd1);
    check("mrst_busy",  16'(o_busy),  16'd0);
    check("mrst_done",  16'(o_done),  16'd0);
    tick();
    i_rst = 1'b1;
    tick();
    check("mrst_hold_lost", 16'(o_busy), 16'd0);

    // i_cpha toggled mid-frame has no effect
    i_cpha = 1'b0; samp_cpha = 1'b0;
    push_frame(8'hB4);
    write(8'hB4);
    tick();
    i_cpha = 1'b1;
    pairs(8);
    i_cpha = 1'b0;
    check("b4_end_busy", 16'(o_busy), 16'd0);

    repeat (3) tick();
    check("bits_drained", 16'(exp_bits.size()), 16'd0);
    check("done_drained", 16'(exp_done.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_serializer.md
# spi_master_serializer

SPI master transmit path: accepts parallel bytes over a valid/ready handshake and shifts them onto MOSI, one bit per SCLK edge strobe from the master clock generator. It is the transmit counterpart of the master deserializer, sharing the same edge strobes and CPHA input. A one-entry holding buffer allows back-to-back bytes with no gap between the last bit of one byte and the first bit of the next.

## Interface
- WIDTH, 8, bits per frame (2..16)
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_data  in  WIDTH  parallel byte to transmit
- i_valid  in  1  i_data valid
- o_ready  out  1  holding buffer empty; transfer occurs when i_valid && o_ready
- i_lead_en  in  1  one-cycle strobe at SCLK leading edge
- i_trail_en  in  1  one-cycle strobe at SCLK trailing edge
- i_cpha  in  1  clock phase: 0 = drive on trail / sample on lead; 1 = drive on lead / sample on trail
- i_abort  in  1  synchronous flush (CS deassert)
- o_mosi  out  1  serial data out
- o_busy  out  1  frame in shift register
- o_done  out  1  one-cycle pulse, frame fully sampled

## Operation
- States: IDLE, ARMED (CPHA=1, waiting for first lead), SHIFT.
- Holding buffer: written on i_valid && o_ready; o_ready = !hold_full.
- Load: hold -> shift register when in IDLE, or at frame completion; hold cleared; bit counter = 0; i_cpha latched into cpha_q (i_cpha changes mid-frame ignored).
- Bit order LSB first (default).
- cpha_q=0: at load o_mosi <= data[0], state SHIFT; each i_trail_en drives next bit.
- cpha_q=1: at load state ARMED, o_mosi unchanged; each i_lead_en drives next bit (first one drives bit 0, ARMED -> SHIFT).
- Counter increments on each i_trail_en in SHIFT; WIDTH-th trail_en = completion.
- Completion: o_done pulses next cycle; if hold full, load immediately (cpha_q=0: o_mosi <= new bit 0 on same edge); else -> IDLE, o_mosi <= 0.
- i_lead_en and i_trail_en together: illegal; trail processed, lead ignored.
- i_abort: hold and shift cleared, counter 0, IDLE, o_mosi 0, no o_done; i_valid in same cycle not accepted.
- o_busy = state != IDLE.

## Timing
- Reset values: o_mosi 0, o_ready 1, o_busy 0, o_done 0, state IDLE, counter 0.
- Handshake at edge N: o_ready low after N; load at N+1 (if IDLE); o_busy high, o_ready high after N+1; cpha_q=0 bit 0 on o_mosi after N+1.
- Frame length: exactly WIDTH trail strobes after load.
- o_done: registered, high for the one cycle after the completion edge.
- Back-to-back (hold full at completion): o_busy stays 1, no idle bit.
- Reset mid-frame: immediate return to reset values, frame lost.

## Configuration
- SPI_SER_MSB_FIRST_EN defined: MSB first (data[WIDTH-1] first, shift left).
- Undefined: LSB first (data[0] first, shift right), matching the deserializer default.

## Structure
- spi_pkg: state enum (IDLE/ARMED/SHIFT), default WIDTH, MOSI idle level constant, counter width = $clog2(WIDTH+1).
- One sub-module: spi_tx_hold (one-entry valid/ready buffer, clear input for abort).
- Shift register, counter, FSM in top.

## Test plan
- CPHA=0, write 0xA5 -> o_mosi 1,0,1,0,0,1,0,1 across 8 trail intervals; o_done once after 8th trail; o_mosi 0, o_busy 0 after.
- CPHA=1, write 0x3C -> o_mosi stays 0 until first lead, then 0,0,1,1,1,1,0,0 on successive leads; done after 8th trail.
- Back-to-back 0x01 then 0x80, second written while first shifting -> 16 contiguous bits, o_busy never drops, two o_done pulses 8 trails apart.
- o_ready low with hold full; i_valid held with 0xFF -> not accepted until completion empties hold.
- i_abort at bit 4 of 0x55 -> o_mosi 0, o_busy 0, o_ready 1 next cycle, no o_done; next byte 0x0F transmits cleanly.
- i_rst asserted mid-frame with hold full -> all outputs at reset values; i_cpha toggled mid-frame -> no effect on current frame.
